// File: rtl/token_fifo_n_pkg.sv
// token_fifo_n_pkg: shared constants and elaboration helpers for the
// data-less token FIFO (occupancy counter width, parameter legality).
package token_fifo_n_pkg;

    // Bits needed to hold every occupancy value 0..depth.
    function automatic int cnt_w(input int depth);
        int w = 1;
        while ((1 << w) < depth + 1) w++;
        return w;
    endfunction

    // Capacity must be at least one token and the almost-full threshold
    // must lie inside 1..depth so the flag is meaningful.
    function automatic bit params_legal(input int depth, input int afull_lvl);
        return (depth >= 1) && (afull_lvl >= 1) && (afull_lvl <= depth);
    endfunction

endpackage

// File: rtl/token_fifo_n.sv
// token_fifo_n: data-less FIFO of DEPTH tokens. Tracks occupancy with
// enqueue/dequeue handshakes, a synchronous clear, an almost-full flag and
// sticky flags for illegal enqueue (while full) and dequeue (while empty).
// All outputs decode the registered state only; ENQ/DEQ/CLR never reach an
// output combinationally, so callers may gate ENQ/DEQ with FULL_N/EMPTY_N.
module token_fifo_n
    import token_fifo_n_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int GUARDED   = 1,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ENQ,
    input  logic                     DEQ,
    input  logic                     CLR,
    output logic                     FULL_N,
    output logic                     EMPTY_N,
    output logic                     ALMOST_FULL,
    output logic [cnt_w(DEPTH)-1:0]  COUNT,
    output logic                     ENQ_ERR,
    output logic                     DEQ_ERR
);

    localparam int            CW      = cnt_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

    // Reject an unusable configuration while elaborating, not in silicon.
    if (!params_legal(DEPTH, AFULL_LVL)) begin : g_param_err
        $error("token_fifo_n: need DEPTH >= 1 and 1 <= AFULL_LVL <= DEPTH");
    end

    logic [CW-1:0] count;
    logic          enq_err_q;
    logic          deq_err_q;

    logic is_full;
    logic is_empty;
    logic deq_ok;
    logic enq_ok;
    logic enq_bad;
    logic deq_bad;

    // Decide which handshakes are accepted this cycle and which are illegal.
    // An unguarded FIFO may accept ENQ while full only when a DEQ frees the slot.
    always_comb begin
        is_full  = (count == DEPTH_C);
        is_empty = (count == '0);
        deq_ok   = DEQ && !is_empty;
        enq_ok   = ENQ && (!is_full || ((GUARDED == 0) && DEQ));
        enq_bad  = ENQ && is_full && ((GUARDED != 0) || !DEQ);
        deq_bad  = DEQ && is_empty;
    end

    // Occupancy update: reset and clear empty the FIFO, otherwise +enq -deq.
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            count <= '0;
        end else if (enq_ok && !deq_ok) begin
            count <= count + CW'(1);
        end else if (deq_ok && !enq_ok) begin
            count <= count - CW'(1);
        end
    end

    // Sticky error flags, cleared only by reset or clear.
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            enq_err_q <= 1'b0;
            deq_err_q <= 1'b0;
        end else begin
            if (enq_bad) enq_err_q <= 1'b1;
            if (deq_bad) deq_err_q <= 1'b1;
        end
    end

    // Status outputs decoded from registered state only.
    always_comb begin
        FULL_N      = !is_full;
        EMPTY_N     = !is_empty;
        ALMOST_FULL = (count >= AFULL_C);
        COUNT       = count;
        ENQ_ERR     = enq_err_q;
        DEQ_ERR     = deq_err_q;
    end

endmodule

// File: tb/tb_token_fifo_n.sv
// tb_token_fifo_n: checks token_fifo_n with a directed vector table on two
// DEPTH=4 instances (guarded and unguarded) sharing stimulus, a hand-written
// latency sequence, then random traffic against an occupancy model and, for
// DEPTH=1, against the legacy single-slot data-less FIFO behaviour.
module tb_token_fifo_n;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic enq = 1'b0, deq = 1'b0, clr = 1'b0;
    logic enq1 = 1'b0, deq1 = 1'b0, clr1 = 1'b0;

    logic [2:0] cnt_g, cnt_u;
    logic [0:0] cnt_1;
    logic fn_g, en_g, af_g, ee_g, de_g;
    logic fn_u, en_u, af_u, ee_u, de_u;
    logic fn_1, en_1, af_1, ee_1, de_1;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    token_fifo_n #(.DEPTH(4), .GUARDED(1), .AFULL_LVL(3)) dut_g (
        .CLK(CLK), .RST(RST), .ENQ(enq), .DEQ(deq), .CLR(clr),
        .FULL_N(fn_g), .EMPTY_N(en_g), .ALMOST_FULL(af_g), .COUNT(cnt_g),
        .ENQ_ERR(ee_g), .DEQ_ERR(de_g));

    token_fifo_n #(.DEPTH(4), .GUARDED(0), .AFULL_LVL(3)) dut_u (
        .CLK(CLK), .RST(RST), .ENQ(enq), .DEQ(deq), .CLR(clr),
        .FULL_N(fn_u), .EMPTY_N(en_u), .ALMOST_FULL(af_u), .COUNT(cnt_u),
        .ENQ_ERR(ee_u), .DEQ_ERR(de_u));

    token_fifo_n #(.DEPTH(1), .GUARDED(1), .AFULL_LVL(1)) dut_1 (
        .CLK(CLK), .RST(RST), .ENQ(enq1), .DEQ(deq1), .CLR(clr1),
        .FULL_N(fn_1), .EMPTY_N(en_1), .ALMOST_FULL(af_1), .COUNT(cnt_1),
        .ENQ_ERR(ee_1), .DEQ_ERR(de_1));

    typedef struct {
        bit rst, clr, enq, deq;
        int cg, cu;
        bit eeg, eeu, de;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input bit r, c, e, d, input int cg, cu,
                        input bit eeg, eeu, de);
        vec_t v;
        v.rst = r; v.clr = c; v.enq = e; v.deq = d;
        v.cg = cg; v.cu = cu; v.eeg = eeg; v.eeu = eeu; v.de = de;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Occupancy model stated from the handshake rules: a DEQ needs a token,
    // an ENQ needs a free slot, where an unguarded FIFO counts the slot being
    // freed by this cycle's DEQ.
    function automatic void model_step(input bit c, e, d, input int depth,
                                       input bit guarded, inout int cnt,
                                       inout bit ee, inout bit de);
        bit took;
        bit put;
        int space;
        if (c) begin
            cnt = 0; ee = 1'b0; de = 1'b0;
            return;
        end
        took  = d && (cnt > 0);
        if (d && cnt == 0) de = 1'b1;
        space = depth - cnt + ((took && !guarded) ? 1 : 0);
        put   = e && (space > 0);
        if (e && !put) ee = 1'b1;
        cnt   = cnt + int'(put) - int'(took);
    endfunction

    task automatic chk_inst(input string nm, input int depth, input int afl,
                            input int ac, input bit fn, en, af, ee, de,
                            input int mc, input bit mee, mde);
        bit ok;
        ok = (ac == mc) && (fn == (mc < depth)) && (en == (mc > 0)) &&
             (af == (mc >= afl)) && (ee == mee) && (de == mde);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got cnt=%0d fn=%0d en=%0d af=%0d ee=%0d de=%0d, expected cnt=%0d ee=%0d de=%0d",
                     nm, ac, fn, en, af, ee, de, mc, mee, mde);
        end
    endtask

    int  mc_g, mc_u, mc_1;
    bit  mee_g, mde_g, mee_u, mde_u, mee_1, mde_1;
    bit  leg_full;

    initial begin
        // Directed table: rst, clr, enq, deq, count_g, count_u, ee_g, ee_u, de
        addv(1,0,0,0, 0,0, 0,0,0);
        addv(1,0,0,0, 0,0, 0,0,0);
        addv(0,0,1,0, 1,1, 0,0,0);
        addv(0,0,1,0, 2,2, 0,0,0);
        addv(0,0,1,0, 3,3, 0,0,0);
        addv(0,0,1,0, 4,4, 0,0,0);
        addv(0,0,1,1, 3,4, 1,0,0);   // full: guarded drops ENQ, unguarded swaps
        addv(0,0,1,0, 4,4, 1,1,0);   // unguarded ENQ alone while full
        addv(0,1,0,0, 0,0, 0,0,0);
        addv(0,0,0,1, 0,0, 0,0,1);   // DEQ on empty
        addv(0,0,1,1, 1,1, 0,0,1);   // ENQ still lands, DEQ_ERR sticky
        addv(0,1,0,0, 0,0, 0,0,0);
        addv(0,0,1,0, 1,1, 0,0,0);
        addv(0,0,1,0, 2,2, 0,0,0);
        for (int k = 0; k < 5; k++) addv(0,0,1,1, 2,2, 0,0,0);
        addv(0,0,1,0, 3,3, 0,0,0);
        addv(0,1,1,0, 0,0, 0,0,0);   // CLR beats ENQ
        addv(0,0,1,0, 1,1, 0,0,0);
        addv(0,0,1,0, 2,2, 0,0,0);
        addv(0,0,1,0, 3,3, 0,0,0);
        addv(1,1,1,0, 0,0, 0,0,0);   // RST beats CLR and ENQ
        addv(0,0,1,0, 1,1, 0,0,0);
        addv(0,0,1,0, 2,2, 0,0,0);
        addv(1,0,1,0, 0,0, 0,0,0);   // RST mid-fill
        for (int k = 1; k <= 4; k++) addv(0,0,1,0, k,k, 0,0,0);
        for (int k = 3; k >= 0; k--) addv(0,0,0,1, k,k, 0,0,0);
        addv(0,0,0,1, 0,0, 0,0,1);
        addv(1,0,0,0, 0,0, 0,0,0);   // reset clears sticky DEQ_ERR

        foreach (vq[i]) begin
            RST = vq[i].rst; clr = vq[i].clr; enq = vq[i].enq; deq = vq[i].deq;
            @(posedge CLK);
            #1;
            chk($sformatf("r%0d count_g", i), int'(cnt_g), vq[i].cg);
            chk($sformatf("r%0d count_u", i), int'(cnt_u), vq[i].cu);
            chk($sformatf("r%0d full_n_g", i), int'(fn_g), int'(vq[i].cg < 4));
            chk($sformatf("r%0d empty_n_g", i), int'(en_g), int'(vq[i].cg > 0));
            chk($sformatf("r%0d afull_g", i), int'(af_g), int'(vq[i].cg >= 3));
            chk($sformatf("r%0d full_n_u", i), int'(fn_u), int'(vq[i].cu < 4));
            chk($sformatf("r%0d empty_n_u", i), int'(en_u), int'(vq[i].cu > 0));
            chk($sformatf("r%0d afull_u", i), int'(af_u), int'(vq[i].cu >= 3));
            chk($sformatf("r%0d enq_err_g", i), int'(ee_g), int'(vq[i].eeg));
            chk($sformatf("r%0d enq_err_u", i), int'(ee_u), int'(vq[i].eeu));
            chk($sformatf("r%0d deq_err_g", i), int'(de_g), int'(vq[i].de));
            chk($sformatf("r%0d deq_err_u", i), int'(de_u), int'(vq[i].de));
            if (vq[i].rst) begin
                chk($sformatf("r%0d count_1", i), int'(cnt_1), 0);
                chk($sformatf("r%0d empty_n_1", i), int'(en_1), 0);
            end
        end

        // Latency: ENQ raised mid-cycle must not show until the next edge.
        RST = 1'b0; clr = 1'b0; deq = 1'b0; enq = 1'b1;
        #2;
        chk("latency pre-edge count_g", int'(cnt_g), 0);
        chk("latency pre-edge empty_n_g", int'(en_g), 0);
        @(posedge CLK);
        #1;
        enq = 1'b0;
        chk("latency post-edge count_g", int'(cnt_g), 1);
        chk("latency post-edge empty_n_g", int'(en_g), 1);

        // Random phase from a clean reset.
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        mc_g = 0; mc_u = 0; mc_1 = 0;
        mee_g = 0; mde_g = 0; mee_u = 0; mde_u = 0; mee_1 = 0; mde_1 = 0;
        leg_full = 1'b0;

        for (int n = 0; n < 10000; n++) begin
            enq  = 1'($urandom_range(0, 1));
            deq  = 1'($urandom_range(0, 1));
            clr  = ($urandom_range(0, 31) == 0);
            enq1 = 1'($urandom_range(0, 1));
            deq1 = 1'($urandom_range(0, 1));
            clr1 = ($urandom_range(0, 31) == 0);

            model_step(clr, enq, deq, 4, 1'b1, mc_g, mee_g, mde_g);
            model_step(clr, enq, deq, 4, 1'b0, mc_u, mee_u, mde_u);
            model_step(clr1, enq1, deq1, 1, 1'b1, mc_1, mee_1, mde_1);

            // Legacy single-slot FIFO: ENQ overrides DEQ. The one known
            // divergence (ENQ+DEQ while full) is expected to empty here.
            if (clr1)                         leg_full = 1'b0;
            else if (enq1 && deq1 && leg_full) leg_full = 1'b0;
            else if (enq1)                    leg_full = 1'b1;
            else if (deq1)                    leg_full = 1'b0;

            @(posedge CLK);
            #1;
            chk_inst($sformatf("rand%0d g", n), 4, 3, int'(cnt_g), fn_g, en_g,
                     af_g, ee_g, de_g, mc_g, mee_g, mde_g);
            chk_inst($sformatf("rand%0d u", n), 4, 3, int'(cnt_u), fn_u, en_u,
                     af_u, ee_u, de_u, mc_u, mee_u, mde_u);
            chk_inst($sformatf("rand%0d d1", n), 1, 1, int'(cnt_1), fn_1, en_1,
                     af_1, ee_1, de_1, mc_1, mee_1, mde_1);
            chk($sformatf("rand%0d legacy full_n", n), int'(fn_1), int'(!leg_full));
            chk($sformatf("rand%0d legacy empty_n", n), int'(en_1), int'(leg_full));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
